// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_COMMIT,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * HDR_BYTES;

  // An image must contain at least one word and fit in instruction memory.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int unsigned words);
    return (len != '0) && (32'(len) <= words);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects stream bytes LSB-first and presents a full little-endian word on the 4th push.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (push) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Newest byte enters at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (push) begin
      shreg <= {byte_data, shreg[23:8]};
    end
  end

  assign word_valid = push && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length header, packs bytes into words, writes them to
// instruction memory and holds the core in reset until the image is committed.
module imem_loader
  import loader_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int CNT_W = $clog2(WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wd,
  output logic             cpu_rst,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  loader_state_t    state, nxt;
  logic [7:0]       len_lo;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic [LEN_W-1:0] hdr_len;
  logic             last_word;
  logic             pk_clear, pk_push, word_valid;
  logic [31:0]      word;

  assign accept    = in_valid && in_ready;
  assign hdr_len   = {in_data, len_lo};
  assign last_word = ((idx + CNT_W'(1)) == len);
  assign pk_clear  = (state == S_HDR1) && accept;
  assign pk_push   = (state == S_DATA) && accept;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .push       (pk_push),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_HDR0;
      S_HDR0:   if (accept) nxt = S_HDR1;
      S_HDR1:   if (accept) nxt = len_legal(hdr_len, WORDS) ? S_DATA : S_ERR;
      S_DATA:   if (word_valid && last_word) nxt = S_COMMIT;
      S_COMMIT: nxt = S_DONE;
      S_DONE:   if (start) nxt = S_HDR0;
      S_ERR:    if (start) nxt = S_HDR0;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wd      <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_lo       <= '0;
      len          <= '0;
      idx          <= '0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == S_HDR0) || (nxt == S_HDR1) || (nxt == S_DATA);
      done     <= (nxt == S_DONE);
      error    <= (nxt == S_ERR);
      cpu_rst  <= (nxt != S_DONE);
      imem_we  <= 1'b0;

      if ((state == S_HDR0) && accept) begin
        len_lo <= in_data;
      end

      if (pk_clear) begin
        len          <= hdr_len[CNT_W-1:0];
        idx          <= '0;
        words_loaded <= '0;
      end

      // idx stops at the final word so it never leaves the memory range.
      if (word_valid) begin
        imem_we   <= 1'b1;
        imem_wd   <= word;
        imem_addr <= 32'(idx) << 2;
        if (!last_word) begin
          idx <= idx + CNT_W'(1);
        end
        if (words_loaded != len) begin
          words_loaded <= words_loaded + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them sequentially into instruction memory through a dedicated write port. It holds the core in reset (`cpu_rst`) until the whole image is committed.

## Interface
- `WORDS`, 256: instruction memory depth in words; maximum image length.
- `CNT_W`, $clog2(WORDS)+1: width of word counters.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load session; sampled only in IDLE, DONE, ERR.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a transfer occurs on an edge with `in_valid && in_ready`.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  32  byte address of the write, always word-aligned (index*4).
- `imem_wd`  out  32  write word.
- `cpu_rst`  out  1  active-high reset to the core's PC register; high in every state except DONE.
- `done`  out  1  image fully written; core released.
- `error`  out  1  header length illegal.
- `words_loaded`  out  CNT_W  words written in the current session.

## Operation
- Stream format: 2-byte little-endian header N (word count), then 4N bytes, each word's LSB first.
- FSM states: IDLE, HDR0, HDR1, DATA, COMMIT, DONE, ERR.
- IDLE: `in_ready`=0. `start` -> HDR0.
- HDR0: `in_ready`=1. An accepted byte goes to len[7:0] -> HDR1.
- HDR1: `in_ready`=1. An accepted byte goes to len[15:8]. If the 16-bit len is 0 or >WORDS -> ERR, else -> DATA. Clear the index and `words_loaded`.
- DATA: `in_ready`=1. A 2-bit byte counter shifts bytes into a 24-bit buffer. On the 4th accepted byte:
  - register `imem_wd`={in_data, buf[23:0]}, `imem_addr`=idx<<2, `imem_we`=1 for the next cycle only;
  - increment idx and `words_loaded`;
  - if idx+1==len -> COMMIT, else stay in DATA with the byte counter at 0.
- COMMIT: `in_ready`=0. This state carries the final `imem_we` pulse. Unconditionally -> DONE.
- DONE: `done`=1, `cpu_rst`=0, `in_ready`=0. `start` -> HDR0 (reload). `done` clears and `cpu_rst` re-asserts on the next cycle.
- ERR: `error`=1, `cpu_rst`=1, `in_ready`=0. `start` -> HDR0 and clears `error`.
- `start` is ignored in HDR0, HDR1, DATA and COMMIT.
- In IDLE/DONE/ERR, a `start` arriving together with `in_valid` accepts no byte, because `in_ready`=0 that cycle.
- Bytes offered while `in_ready`=0 are not consumed.

## Timing
- Reset (async, `rst`=0) forces:
  - state IDLE;
  - `cpu_rst`=1;
  - `in_ready`, `imem_we`, `done`, `error`=0;
  - `imem_addr`, `imem_wd`, `words_loaded`=0.
- Reset mid-load abandons the session. Memory contents already written are left as-is and are not guaranteed.
- Write latency: `imem_we` is high in the cycle immediately after the 4th byte of a word is accepted.
- Throughput: one byte per cycle when `in_valid` is held high; no bubbles between words in DATA.
- Release: `done` rises and `cpu_rst` falls exactly one cycle after the final `imem_we` pulse. Word 0 is therefore already committed when the core fetches PC=0.
- Back-to-back N=1 loads work; each session rewrites from address 0.
- `words_loaded` saturates at len and never wraps; idx never exceeds WORDS-1.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`;
  - `HDR_BYTES`=2 and `BYTES_PER_WORD`=4;
  - function computing the legal-length check.
- Sub-module `byte_packer`: 2-bit byte counter plus 24-bit shift buffer.
  - Inputs: `clk`, `rst`, `clear`, `push`, `byte`.
  - Outputs: `word_valid` (pulse) and `word`.
- The FSM, index/address generation and output registers stay in `imem_loader`.

## Test plan
- Basic load: reset, `start`, header 02 00, bytes 13 05 00 00 93 05 10 00.
  - Expect `imem_we` at addr 0x0 with 0x00000513, then at addr 0x4 with 0x00100593.
  - One cycle after the second pulse: `done`=1, `cpu_rst`=0, `words_loaded`=2.
- Backpressure/gaps: same image with `in_valid` toggling every other cycle and random gaps. Expect identical writes, no duplicated or dropped bytes, and exactly 2 `imem_we` pulses.
- Illegal header, no `imem_we` in either case:
  - header 00 00 -> `error`=1, `cpu_rst`=1;
  - header 01 01 (257) with WORDS=256 -> `error`=1;
  - a following `start` clears `error`.
- Full image: N=256 (header 00 01). Expect the last write at addr 0x3FC, `words_loaded`=256, then `done`=1.
- Reset mid-DATA: drive `rst`=0 after 5 data bytes.
  - All outputs return to reset values immediately (asynchronously), `cpu_rst`=1.
  - A fresh load afterwards writes from addr 0.
- Reload from DONE: `start` -> next cycle `done`=0, `cpu_rst`=1, `in_ready`=1. A new 1-word image writes addr 0, then `done`=1.
